// File: rtl/fadd_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : fadd_arbiter
//  Description : Shares one fixed-latency pipelined fadd unit between NREQ
//                requesters. Round-robin grant, a tag pipeline that follows
//                each operation through the fadd, per-requester result FIFOs,
//                and credits that reserve a FIFO slot for every issued op.
//  Revision    : 1.0 - initial release
// ============================================================================
module fadd_arbiter #(
  parameter int NREQ   = 2,
  parameter int NSTAGE = 2,
  parameter int RDEPTH = 2
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [NREQ-1:0]    req_valid,
  output logic [NREQ-1:0]    req_ready,
  input  logic [32*NREQ-1:0] req_x1,
  input  logic [32*NREQ-1:0] req_x2,
  output logic [NREQ-1:0]    resp_valid,
  input  logic [NREQ-1:0]    resp_ready,
  output logic [32*NREQ-1:0] resp_y,
  output logic [NREQ-1:0]    resp_ovf,
  output logic [31:0]        fadd_x1,
  output logic [31:0]        fadd_x2,
  input  logic [31:0]        fadd_y,
  input  logic               fadd_ovf,
  output logic               busy
);

  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW  = $clog2(RDEPTH + 1);
  localparam int PW  = (RDEPTH > 1) ? $clog2(RDEPTH) : 1;
  localparam logic [IDW-1:0] LAST_ID     = IDW'(NREQ - 1);
  localparam logic [PW-1:0]  LAST_SLOT   = PW'(RDEPTH - 1);
  localparam logic [CW-1:0]  FULL_CREDIT = CW'(RDEPTH);

  logic [IDW-1:0]  ptr;
  logic [NREQ-1:0] has_credit;
  logic [NREQ-1:0] eligible;
  logic [NREQ-1:0] grant;
  logic [IDW-1:0]  grant_id;
  logic            grant_any;

  logic [NSTAGE:0] tag_v;
  logic [IDW-1:0]  tag_id [NSTAGE+1];

  logic [NREQ-1:0] push;
  logic [NREQ-1:0] pop;
  logic [NREQ-1:0] nonempty;

  // Gating with rstn keeps req_ready low while the block is held in reset.
  assign eligible  = req_valid & has_credit & {NREQ{rstn}};
  assign req_ready = grant;
  assign busy      = (|tag_v) | (|nonempty);

  // Round-robin search starting one past the last granted requester.
  always_comb begin
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!grant_any && eligible[(int'(ptr) + k) % NREQ]) begin
        grant[(int'(ptr) + k) % NREQ] = 1'b1;
        grant_id  = IDW'((int'(ptr) + k) % NREQ);
        grant_any = 1'b1;
      end
    end
  end

  // Operand register feeding the fadd; holds its value on idle cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fadd_x1 <= '0;
      fadd_x2 <= '0;
      ptr     <= LAST_ID;
    end else if (grant_any) begin
      fadd_x1 <= req_x1[32*int'(grant_id) +: 32];
      fadd_x2 <= req_x2[32*int'(grant_id) +: 32];
      ptr     <= grant_id;
    end
  end

  // Tag pipeline: stage NSTAGE lines up with the fadd result on its inputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tag_v <= '0;
      for (int s = 0; s <= NSTAGE; s++) begin
        tag_id[s] <= '0;
      end
    end else begin
      tag_v     <= {tag_v[NSTAGE-1:0], grant_any};
      tag_id[0] <= grant_id;
      for (int s = 1; s <= NSTAGE; s++) begin
        tag_id[s] <= tag_id[s-1];
      end
    end
  end

  genvar i;
  generate
    for (i = 0; i < NREQ; i++) begin : g_req
      logic [32:0]   mem [RDEPTH];
      logic [PW-1:0] wp;
      logic [PW-1:0] rp;
      logic [CW-1:0] cnt;
      logic [CW-1:0] credit;
      logic [32:0]   head;

      assign push[i]       = tag_v[NSTAGE] && (tag_id[NSTAGE] == IDW'(i));
      assign nonempty[i]   = (cnt != '0);
      assign pop[i]        = nonempty[i] && resp_ready[i];
      assign has_credit[i] = (credit != '0);
      assign head          = mem[rp];

      assign resp_valid[i]      = nonempty[i];
      assign resp_y[32*i +: 32] = nonempty[i] ? head[31:0] : 32'd0;
      assign resp_ovf[i]        = nonempty[i] & head[32];

      // Result storage; no reset needed because cnt qualifies every read.
      always_ff @(posedge clk) begin
        if (push[i]) begin
          mem[wp] <= {fadd_ovf, fadd_y};
        end
      end

      // FIFO pointers and occupancy; write and pop together leave cnt alone.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          wp  <= '0;
          rp  <= '0;
          cnt <= '0;
        end else begin
          if (push[i]) begin
            wp <= (wp == LAST_SLOT) ? '0 : wp + 1'b1;
          end
          if (pop[i]) begin
            rp <= (rp == LAST_SLOT) ? '0 : rp + 1'b1;
          end
          if (push[i] && !pop[i]) begin
            cnt <= cnt + 1'b1;
          end else if (!push[i] && pop[i]) begin
            cnt <= cnt - 1'b1;
          end
        end
      end

      // Credits: one consumed per grant, one returned per pop.
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          credit <= FULL_CREDIT;
        end else if (grant[i] && !pop[i]) begin
          credit <= credit - 1'b1;
        end else if (!grant[i] && pop[i]) begin
          credit <= credit + 1'b1;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire
